memory_responder: RTL and testbench

Memory-side responder for the multicycle CPU's data/instruction accesses. It takes one load or store request at a time from the control unit over a valid/ready handshake and services it against a word-wide synchronous RAM with one-cycle read latency. It performs byte/halfword lane extraction on loads, with optional sign extension. It performs read-modify-write on sub-word stores and flags misaligned or illegal-size requests without touching RAM.

---
 rtl/memory_responder.sv | 171 +++++++++++++++++
 tb/tb_memory_responder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_responder.sv
// memory_responder
//   Services one load or store at a time from the control unit against a
//   word-wide synchronous RAM (one-cycle read latency). Loads get byte/half
//   lane extraction with optional sign extension; sub-word stores are done as
//   read-modify-write; misaligned or illegal-size requests are answered with
//   an error and never touch RAM.
//
// Handshake: a request transfers on a rising clock edge where
//   req_valid & req_ready are both high. req_ready is high only while the FSM
//   is idle and reset is released; request fields are captured on that edge
//   and ignored afterwards. resp_valid is a single-cycle pulse with no ready;
//   resp_error and resp_rdata qualify it.
//
// Ports
//   clock, reset            clock, synchronous active-low reset
//   req_*                   request channel (valid/ready), byte address,
//                           right-aligned store data
//   resp_valid/rdata/error  one-cycle response, registered
//   ram_addr/we/wdata       RAM port, registered
//   ram_rdata               RAM read data, valid one cycle after ram_addr
//   debug_state             current FSM state encoding
module memory_responder #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [31:0]           ram_wdata,
    input  logic [31:0]           ram_rdata,
    output logic [2:0]            debug_state
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WAIT = 3'd2,
        WR   = 3'd3,
        RESP = 3'd4
    } state_t;

    state_t state, state_next;

    // Latched request fields
    logic        write_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  off_q;
    logic [31:0] data_q;   // store data, later replaced by the merged word

    logic        accept;
    logic        req_bad;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] lane_mask;
    logic [31:0] mask;
    logic [31:0] merged;
    logic [31:0] load_val;

    // Address bits above the RAM range alias; they are intentionally unused.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

    assign req_ready   = (state == IDLE) && reset;
    assign accept      = req_valid && req_ready;
    assign debug_state = state;

    always_comb begin
        req_bad = 1'b0;
        case (req_size)
            2'b00:   req_bad = 1'b0;
            2'b01:   req_bad = req_addr[0];
            2'b10:   req_bad = (req_addr[1:0] != 2'b00);
            default: req_bad = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_bad)
                        state_next = RESP;
                    else if (req_write && (req_size == 2'b10))
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:      state_next = WAIT;
            WAIT:    state_next = write_q ? WR : RESP;
            WR:      state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lane handling: one shift amount serves both extraction and merging,
    // since a half at offset 2 is the same as a byte-lane shift of 16.
    always_comb begin
        shamt     = {off_q, 3'b000};
        shifted   = ram_rdata >> shamt;
        lane_mask = (size_q == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        mask      = lane_mask << shamt;
        merged    = (ram_rdata & ~mask) | ((data_q << shamt) & mask);
        case (size_q)
            2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
            default: load_val = ram_rdata;
        endcase
    end

    // All outputs are registered, so each trails the state that produces it
    // by one cycle: ram_we is high the cycle after WR, resp_valid the cycle
    // after RESP.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 32'h0;
            write_q    <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            off_q      <= 2'b00;
            data_q     <= 32'h0;
        end else begin
            state      <= state_next;
            resp_valid <= (state == RESP);
            ram_we     <= (state == WR);

            if (accept) begin
                write_q  <= req_write;
                size_q   <= req_size;
                signed_q <= req_signed;
                off_q    <= req_addr[1:0];
                ram_addr <= req_addr[ADDR_WIDTH+1:2];
                data_q   <= req_wdata;
            end

            if ((state == WAIT) && write_q)
                data_q <= merged;

            if (state == WR)
                ram_wdata <= data_q;

            // Response payload is captured on entry to RESP. Only a load
            // arriving from WAIT carries data; RESP straight from IDLE is an
            // error.
            if ((state_next == RESP) && (state != RESP)) begin
                resp_rdata <= ((state == WAIT) && !write_q) ? load_val : 32'h0;
                resp_error <= (state == IDLE);
            end
        end
    end

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  localparam int AW = 8;

  logic          clock;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [1:0]    req_size;
  logic          req_signed;
  logic [31:0]   req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_error;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;
  logic [2:0]    debug_state;

  memory_responder #(.ADDR_WIDTH(AW)) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_size    (req_size),
    .req_signed  (req_signed),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .resp_valid  (resp_valid),
    .resp_rdata  (resp_rdata),
    .resp_error  (resp_error),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .debug_state (debug_state)
  );

  // ---------------- clock / reset / RAM ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  int accept_cnt = 0;
  always @(posedge clock) begin
    if (req_valid && req_ready) accept_cnt <= accept_cnt + 1;
  end

  // ---------------- reference model (byte array) ----------------
  logic [7:0]  ref_bytes [0:(4<<AW)-1];
  logic [32:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic is_bad(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b11) return 1'b1;
    if (sz == 2'b01) return a[0];
    if (sz == 2'b10) return a[1:0] != 2'b00;
    return 1'b0;
  endfunction

  function automatic int byte_idx(input logic [31:0] a);
    return int'(a[AW+1:0]);
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int b;
    b = byte_idx(a);
    ref_bytes[b] = wd[7:0];
    if (sz != 2'b00) ref_bytes[b+1] = wd[15:8];
    if (sz == 2'b10) begin
      ref_bytes[b+2] = wd[23:16];
      ref_bytes[b+3] = wd[31:24];
    end
  endtask

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
    int b;
    logic [31:0] v;
    b = byte_idx(a);
    if (sz == 2'b00) begin
      v = {24'h0, ref_bytes[b]};
      if (sg && ref_bytes[b][7]) v[31:8] = 24'hFFFFFF;
    end else if (sz == 2'b01) begin
      v = {16'h0, ref_bytes[b+1], ref_bytes[b]};
      if (sg && ref_bytes[b+1][7]) v[31:16] = 16'hFFFF;
    end else begin
      v = {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
    end
    return v;
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] a);
    int b;
    b = byte_idx(a) & ~3;
    return {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
  endfunction

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Issues one request, tracks it cycle by cycle from the accept edge and
  // compares the response against the scoreboard entry pushed up front.
  // With hold=1, req_valid stays high and the request fields are scrambled
  // while the responder is busy.
  task automatic do_req(input string tag, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                        input bit hold);
    logic bad;
    int lat, k, we_cnt, rdy_cnt, acc0;
    bit seen;
    logic [32:0] exp;
    bad = is_bad(sz, addr);
    lat = bad ? 1 : (!wr ? 3 : ((sz == 2'b10) ? 2 : 4));
    exp_q.push_back({bad, (bad || wr) ? 32'h0 : exp_rd});
    if (!bad && wr) model_store(sz, addr, wd);

    @(negedge clock);
    k = 0;
    while (!req_ready && k < 10) begin
      @(negedge clock);
      k++;
    end
    acc0       = accept_cnt;
    req_write  = wr;
    req_size   = sz;
    req_signed = sg;
    req_addr   = addr;
    req_wdata  = wd;
    req_valid  = 1'b1;
    @(posedge clock);

    seen = 0; we_cnt = 0; rdy_cnt = 0;
    for (k = 0; k < 12; k++) begin
      @(negedge clock);
      if (resp_valid) begin
        seen = 1;
        break;
      end
      if (ram_we) we_cnt++;
      if (req_ready) rdy_cnt++;
      if (hold) begin
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_write  = 1'($urandom_range(0, 1));
        req_size   = 2'($urandom_range(0, 3));
        req_signed = 1'($urandom_range(0, 1));
      end else begin
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;

    exp = exp_q.pop_front();
    check({tag, " resp_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, " latency"}, k, lat);
      check({tag, " rdata"}, resp_rdata, exp[31:0]);
      check({tag, " error"}, 32'(resp_error), 32'(exp[32]));
      check({tag, " ready_during_resp"}, 32'(req_ready), 32'd1);
    end
    check({tag, " ram_we_cycles"}, we_cnt, (wr && !bad) ? 1 : 0);
    check({tag, " ready_while_busy"}, rdy_cnt, 0);
    @(negedge clock);
    check({tag, " resp_pulse_width"}, 32'(resp_valid), 32'd0);
    check({tag, " accepts"}, accept_cnt - acc0, 1);
    if (wr && !bad) check({tag, " ram_word"}, mem[addr[AW+1:2]], model_word(addr));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int acc0, vcnt, wcnt;
    logic [1:0]  sz;
    logic [31:0] a, wd;
    logic wr, sg;

    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h0;
    for (int i = 0; i < (4 << AW); i++) ref_bytes[i] = 8'h0;

    reset      = 1'b0;
    req_valid  = 1'b1;   // asserted during reset: must not be accepted
    req_write  = 1'b1;
    req_size   = 2'b10;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'hDEAD_BEEF;

    repeat (3) @(negedge clock);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst resp_valid", 32'(resp_valid), 32'd0);
    check("rst resp_error", 32'(resp_error), 32'd0);
    check("rst resp_rdata", resp_rdata, 32'h0);
    check("rst ram_we", 32'(ram_we), 32'd0);
    check("rst ram_addr", 32'(ram_addr), 32'd0);
    check("rst ram_wdata", ram_wdata, 32'h0);
    check("rst state", 32'(debug_state), 32'd0);
    req_valid = 1'b0;
    reset     = 1'b1;
    #1;
    check("rst ready_after_release", 32'(req_ready), 32'd1);
    check("rst no_accept", accept_cnt, 0);

    // Word round trip
    do_req("sw 0x10", 1, 2'b10, 0, 32'h10, 32'h1122_3344, 32'h0, 0);
    do_req("lw 0x10", 0, 2'b10, 0, 32'h10, 32'h0, 32'h1122_3344, 0);

    // Byte store / loads
    do_req("sb 0x13", 1, 2'b00, 0, 32'h13, 32'h0000_00A5, 32'h0, 0);
    check("sb word4", mem[4], 32'hA522_3344);
    do_req("lb 0x13", 0, 2'b00, 1, 32'h13, 32'h0, 32'hFFFF_FFA5, 0);
    do_req("lbu 0x13", 0, 2'b00, 0, 32'h13, 32'h0, 32'h0000_00A5, 0);

    // Half store / loads
    do_req("sh 0x12", 1, 2'b01, 0, 32'h12, 32'h0000_BEEF, 32'h0, 0);
    check("sh word4", mem[4], 32'hBEEF_3344);
    do_req("lh 0x12", 0, 2'b01, 1, 32'h12, 32'h0, 32'hFFFF_BEEF, 0);
    do_req("lhu 0x10", 0, 2'b01, 0, 32'h10, 32'h0, 32'h0000_3344, 0);
    do_req("lb 0x11", 0, 2'b00, 1, 32'h11, 32'h0, 32'h0000_0033, 0);
    do_req("lb 0x12", 0, 2'b00, 1, 32'h12, 32'h0, 32'hFFFF_FFEF, 0);

    // Errors: resp_rdata currently holds 0x3344-era data, so rdata=0 is meaningful
    do_req("lhu hold data", 0, 2'b01, 0, 32'h10, 32'h0, 32'h0000_3344, 0);
    do_req("err lw 0x11", 0, 2'b10, 0, 32'h11, 32'h0, 32'h0, 0);
    do_req("err sh 0x13", 1, 2'b01, 0, 32'h13, 32'hFFFF_FFFF, 32'h0, 0);
    do_req("err size3", 1, 2'b11, 0, 32'h10, 32'hFFFF_FFFF, 32'h0, 0);
    check("err word4", mem[4], 32'hBEEF_3344);

    // Address aliasing: high bits ignored
    do_req("lw alias", 0, 2'b10, 0, 32'hABCD_FC10, 32'h0, 32'hBEEF_3344, 0);

    // Reset during WAIT of a sub-word store
    @(negedge clock);
    acc0       = accept_cnt;
    req_write  = 1'b1;
    req_size   = 2'b00;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'h0000_005A;
    req_valid  = 1'b1;
    @(posedge clock);
    vcnt = 0; wcnt = 0;
    @(negedge clock);          // RD
    req_valid = 1'b0;
    if (ram_we) wcnt++;
    @(negedge clock);          // WAIT
    if (ram_we) wcnt++;
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("midrst ready", 32'(req_ready), 32'd1);
    check("midrst accepts", accept_cnt - acc0, 1);
    for (int i = 0; i < 8; i++) begin
      if (resp_valid) vcnt++;
      if (ram_we) wcnt++;
      @(negedge clock);
    end
    check("midrst resp_valid", vcnt, 0);
    check("midrst ram_we", wcnt, 0);
    check("midrst word4", mem[4], 32'hBEEF_3344);

    // Held req_valid with scrambled fields while busy
    do_req("hold sw 0x80", 1, 2'b10, 0, 32'h80, 32'hCAFE_F00D, 32'h0, 1);
    do_req("hold sb 0x81", 1, 2'b00, 0, 32'h81, 32'h0000_0077, 32'h0, 1);
    do_req("hold lw 0x80", 0, 2'b10, 0, 32'h80, 32'h0, model_load(2'b10, 0, 32'h80), 1);

    // Random mix against the byte model in words 0x40..0x4F
    for (int i = 0; i < 30; i++) begin
      sz = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) sz = 2'b11;
      a  = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) != 0) begin
        if (sz == 2'b01) a[0] = 1'b0;
        if (sz == 2'b10) a[1:0] = 2'b00;
      end
      wr = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      wd = $urandom;
      do_req($sformatf("rnd%0d", i), wr, sz, sg, a, wd, model_load(sz, sg, a), 0);
    end

    check("scoreboard empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
